// File: rtl/pipe_hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight writes EX..WB, load-use stall, forward selects.
// Optional HAZARD_STATS_EN adds saturating stall_cycles / fwd_events counters.
module pipe_hazard_scoreboard #(
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 3,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_STAGES = 1,
  localparam int SEL_W       = $clog2(DEPTH),
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_wr_en,
  input  logic [ADDR_W-1:0] id_waddr,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_sel_rs,
  output logic [SEL_W-1:0]  fwd_sel_rt,
  output logic [CNT_W-1:0]  pend_cnt
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       fwd_events
`endif
);

  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0]             ld_q, ld_d;
  logic [DEPTH-1:0][ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0]            ex_rs_q, ex_rs_d;
  logic [ADDR_W-1:0]            ex_rt_q, ex_rt_d;
  logic                         ex_use_rs_q, ex_use_rs_d;
  logic                         ex_use_rt_q, ex_use_rt_d;
  logic [CNT_W-1:0]             pend_q, pend_d;

  logic             rs_haz, rt_haz;
  logic [SEL_W-1:0] fwd_rs, fwd_rt;
  logic             issue;

  // Descending scan so the youngest (lowest index) match wins.
  always_comb begin
    rs_haz = 1'b0;
    rt_haz = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && waddr_q[i] == id_rs &&
          id_rs != '0 && id_uses_rs)
        rs_haz = ld_q[i] && (i < LOAD_LAT);
      if (vld_q[i] && waddr_q[i] == id_rt &&
          id_rt != '0 && id_uses_rt)
        rt_haz = ld_q[i] && (i < LOAD_LAT);
    end
    stall = id_valid && !flush && (rs_haz || rt_haz);
  end

  // Entry 0 is the EX instruction itself, so it is never a source.
  always_comb begin
    fwd_rs = '0;
    fwd_rt = '0;
    for (int i = DEPTH - 1; i >= 1; i--) begin
      if (vld_q[i] && waddr_q[i] == ex_rs_q &&
          ex_rs_q != '0 && ex_use_rs_q)
        fwd_rs = SEL_W'(i);
      if (vld_q[i] && waddr_q[i] == ex_rt_q &&
          ex_rt_q != '0 && ex_use_rt_q)
        fwd_rt = SEL_W'(i);
    end
  end

  always_comb begin
    vld_d       = vld_q;
    ld_d        = ld_q;
    waddr_d     = waddr_q;
    ex_rs_d     = ex_rs_q;
    ex_rt_d     = ex_rt_q;
    ex_use_rs_d = ex_use_rs_q;
    ex_use_rt_d = ex_use_rt_q;
    issue       = id_valid && !stall && !flush;
    if (enable) begin
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i]   = vld_q[i-1];
        ld_d[i]    = ld_q[i-1];
        waddr_d[i] = waddr_q[i-1];
      end
      vld_d[0]    = issue && id_wr_en && id_waddr != '0;
      ld_d[0]     = id_is_load;
      waddr_d[0]  = id_waddr;
      ex_rs_d     = issue ? id_rs : '0;
      ex_rt_d     = issue ? id_rt : '0;
      ex_use_rs_d = issue && id_uses_rs;
      ex_use_rt_d = issue && id_uses_rt;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i < FLUSH_STAGES)
            vld_d[i] = 1'b0;
        end
      end
    end
    pend_d = '0;
    for (int i = 0; i < DEPTH; i++)
      pend_d = pend_d + CNT_W'(vld_d[i]);
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      vld_q       <= '0;
      ld_q        <= '0;
      waddr_q     <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_use_rs_q <= 1'b0;
      ex_use_rt_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      vld_q       <= vld_d;
      ld_q        <= ld_d;
      waddr_q     <= waddr_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_use_rs_q <= ex_use_rs_d;
      ex_use_rt_q <= ex_use_rt_d;
      pend_q      <= pend_d;
    end
  end

  assign fwd_sel_rs = fwd_rs;
  assign fwd_sel_rt = fwd_rt;
  assign pend_cnt   = pend_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] fwd_events_q, fwd_events_d;
  logic [1:0]  fwd_inc;
  logic [32:0] fwd_sum;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    fwd_events_d   = fwd_events_q;
    fwd_inc        = {1'b0, fwd_rs != '0} + {1'b0, fwd_rt != '0};
    fwd_sum        = {1'b0, fwd_events_q} + {31'b0, fwd_inc};
    if (enable) begin
      if (stall && stall_cycles_q != '1)
        stall_cycles_d = stall_cycles_q + 32'd1;
      fwd_events_d = fwd_sum[32] ? '1 : fwd_sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      fwd_events_q   <= fwd_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_events   = fwd_events_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for pipe_hazard_scoreboard: directed table, multi-cycle sequences, random vs model.
// Two instances: defaults, and DEPTH=4 / LOAD_LAT=2 / FLUSH_STAGES=2.
module tb_pipe_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst_n, enable, id_valid, flush;
  logic       id_uses_rs, id_uses_rt, id_wr_en, id_is_load;
  logic [4:0] id_rs, id_rt, id_waddr;
  logic       sa, sb;
  logic [1:0] frsa, frta, frsb, frtb, pa;
  logic [2:0] pb;
`ifdef HAZARD_STATS_EN
  logic [31:0] sca, fea, scb, feb;
`endif

  pipe_hazard_scoreboard u_a (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_wr_en(id_wr_en), .id_waddr(id_waddr),
    .id_is_load(id_is_load), .flush(flush),
    .stall(sa), .fwd_sel_rs(frsa), .fwd_sel_rt(frta),
    .pend_cnt(pa)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sca), .fwd_events(fea)
`endif
  );

  pipe_hazard_scoreboard #(
    .DEPTH(4), .LOAD_LAT(2), .FLUSH_STAGES(2)
  ) u_b (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_wr_en(id_wr_en), .id_waddr(id_waddr),
    .id_is_load(id_is_load), .flush(flush),
    .stall(sb), .fwd_sel_rs(frsb), .fwd_sel_rt(frtb),
    .pend_cnt(pb)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(scb), .fwd_events(feb)
`endif
  );

  typedef struct packed {
    logic       rst_n, en, flush, valid;
    logic       urs, urt, wr, ld;
    logic [4:0] rs, rt, wa;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic       c;
    logic       st;
    logic [1:0] frs, frt, pc;
  } vec_t;

  typedef struct packed {
    bit       v;
    bit [4:0] wa;
    bit       ld;
  } ent_t;

  typedef ent_t eq_t[$];

  eq_t    qa, qb;
  bit [4:0] xrs[2], xrt[2];
  bit     xurs[2], xurt[2];
  bit     mok = 1'b0;
  int     n_vec = 0, n_bad = 0;
  int     m_sc = 0, m_fe = 0;
  logic   lb_stall;
  logic [1:0] lb_frt;

  function automatic int youngest(eq_t q, bit [4:0] r, int lo);
    for (int k = lo; k < q.size(); k++)
      if (q[k].v && q[k].wa == r) return k;
    return -1;
  endfunction

  function automatic bit m_stall(eq_t q, int ll, in_t v);
    bit h = 1'b0;
    int k;
    if (v.urs && v.rs != 0) begin
      k = youngest(q, v.rs, 0);
      if (k >= 0 && q[k].ld && k < ll) h = 1'b1;
    end
    if (v.urt && v.rt != 0) begin
      k = youngest(q, v.rt, 0);
      if (k >= 0 && q[k].ld && k < ll) h = 1'b1;
    end
    return v.valid && !v.flush && h;
  endfunction

  function automatic int m_fwd(eq_t q, bit u, bit [4:0] r);
    int k;
    if (!u || r == 0) return 0;
    k = youngest(q, r, 1);
    return (k < 0) ? 0 : k;
  endfunction

  function automatic int m_pend(eq_t q);
    int n = 0;
    foreach (q[k]) n += int'(q[k].v);
    return n;
  endfunction

  function automatic eq_t m_next(eq_t q, int dep, int fs,
                                 bit st, in_t v);
    ent_t e;
    if (!v.rst_n) begin
      q.delete();
      for (int k = 0; k < dep; k++) q.push_back('0);
      return q;
    end
    if (!v.en) return q;
    e.v  = v.valid && !st && !v.flush && v.wr && v.wa != 0;
    e.wa = v.wa;
    e.ld = v.ld;
    q.push_front(e);
    void'(q.pop_back());
    if (v.flush)
      for (int k = 0; k < fs && k < q.size(); k++) q[k].v = 1'b0;
    return q;
  endfunction

  function automatic in_t ins(bit val, bit [4:0] rs, bit urs,
                              bit [4:0] rt, bit urt, bit wr,
                              bit [4:0] wa, bit ld, bit fl = 0,
                              bit en = 1, bit rn = 1);
    in_t v;
    v.rst_n = rn; v.en = en; v.flush = fl; v.valid = val;
    v.urs = urs; v.urt = urt; v.wr = wr; v.ld = ld;
    v.rs = rs; v.rt = rt; v.wa = wa;
    return v;
  endfunction

  function automatic vec_t vr(in_t i, bit c, bit st,
                              bit [1:0] frs, bit [1:0] frt,
                              bit [1:0] pc);
    vec_t r;
    r.i = i; r.c = c; r.st = st;
    r.frs = frs; r.frt = frt; r.pc = pc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t v, input bit tc, input logic te_st,
                       input logic [1:0] te_frs,
                       input logic [1:0] te_frt,
                       input logic [1:0] te_pc);
    bit msa, msb, ia, ib;
    int fa_rs, fa_rt, fb_rs, fb_rt;
    @(negedge clk);
    arst_n = v.rst_n; enable = v.en; flush = v.flush;
    id_valid = v.valid; id_uses_rs = v.urs; id_uses_rt = v.urt;
    id_wr_en = v.wr; id_is_load = v.ld;
    id_rs = v.rs; id_rt = v.rt; id_waddr = v.wa;
    #1;
    msa   = m_stall(qa, 1, v);
    msb   = m_stall(qb, 2, v);
    fa_rs = m_fwd(qa, xurs[0], xrs[0]);
    fa_rt = m_fwd(qa, xurt[0], xrt[0]);
    fb_rs = m_fwd(qb, xurs[1], xrs[1]);
    fb_rt = m_fwd(qb, xurt[1], xrt[1]);
    if (mok) begin
      chk("a_stall", {31'b0, sa}, {31'b0, msa});
      chk("a_fwd_rs", {30'b0, frsa}, fa_rs);
      chk("a_fwd_rt", {30'b0, frta}, fa_rt);
      chk("a_pend", {30'b0, pa}, m_pend(qa));
      chk("b_stall", {31'b0, sb}, {31'b0, msb});
      chk("b_fwd_rs", {30'b0, frsb}, fb_rs);
      chk("b_fwd_rt", {30'b0, frtb}, fb_rt);
      chk("b_pend", {29'b0, pb}, m_pend(qb));
`ifdef HAZARD_STATS_EN
      chk("a_stall_cycles", sca, m_sc);
      chk("a_fwd_events", fea, m_fe);
`endif
    end
    if (tc) begin
      chk("t_stall", {31'b0, sa}, {31'b0, te_st});
      chk("t_fwd_rs", {30'b0, frsa}, {30'b0, te_frs});
      chk("t_fwd_rt", {30'b0, frta}, {30'b0, te_frt});
      chk("t_pend", {30'b0, pa}, {30'b0, te_pc});
    end
    lb_stall = sb;
    lb_frt   = frtb;
    if (!v.rst_n) begin
      m_sc = 0; m_fe = 0;
    end else if (v.en) begin
      m_sc += int'(msa);
      m_fe += int'(fa_rs != 0) + int'(fa_rt != 0);
    end
    ia = v.valid && !msa && !v.flush;
    ib = v.valid && !msb && !v.flush;
    if (!v.rst_n) begin
      for (int j = 0; j < 2; j++) begin
        xrs[j] = 0; xrt[j] = 0; xurs[j] = 0; xurt[j] = 0;
      end
    end else if (v.en) begin
      xrs[0] = ia ? v.rs : 5'd0; xrt[0] = ia ? v.rt : 5'd0;
      xurs[0] = ia && v.urs;     xurt[0] = ia && v.urt;
      xrs[1] = ib ? v.rs : 5'd0; xrt[1] = ib ? v.rt : 5'd0;
      xurs[1] = ib && v.urs;     xurt[1] = ib && v.urt;
    end
    qa = m_next(qa, 3, 1, msa, v);
    qb = m_next(qb, 4, 2, msb, v);
    if (!v.rst_n) mok = 1'b1;
    @(posedge clk);
  endtask

  vec_t tbl[$];
  in_t  nop, addu, frz;
  int   scnt;

  initial begin
    nop  = ins(0, 0, 0, 0, 0, 0, 0, 0);
    addu = ins(1, 2, 1, 5, 1, 1, 7, 0);
    frz  = ins(1, 8, 1, 0, 0, 1, 9, 0);
    // reset with toggling inputs
    tbl.push_back(vr(ins(1, 3, 1, 5, 1, 1, 7, 1, 0, 1, 0), 0, 0, 0, 0, 0));
    tbl.push_back(vr(ins(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0), 1, 0, 0, 0, 0));
    // back-to-back forward, then distance-2 forward
    tbl.push_back(vr(ins(1, 1, 1, 2, 1, 1, 3, 0), 1, 0, 0, 0, 0));
    tbl.push_back(vr(ins(1, 3, 1, 4, 1, 1, 6, 0), 1, 0, 0, 0, 1));
    tbl.push_back(vr(nop, 1, 0, 1, 0, 2));
    tbl.push_back(vr(ins(1, 1, 1, 2, 1, 1, 3, 0), 1, 0, 0, 0, 2));
    tbl.push_back(vr(ins(1, 8, 1, 9, 1, 1, 10, 0), 1, 0, 0, 0, 2));
    tbl.push_back(vr(ins(1, 3, 1, 11, 1, 1, 12, 0), 1, 0, 0, 0, 2));
    tbl.push_back(vr(nop, 1, 0, 2, 0, 3));
    // load-use: one stall then forward from entry 2
    tbl.push_back(vr(ins(1, 1, 1, 0, 0, 1, 5, 1), 1, 0, 0, 0, 2));
    tbl.push_back(vr(addu, 1, 1, 0, 0, 2));
    tbl.push_back(vr(addu, 1, 0, 0, 0, 1));
    tbl.push_back(vr(nop, 1, 0, 0, 2, 2));
    // younger non-load shadows the load
    tbl.push_back(vr(ins(1, 1, 1, 0, 0, 1, 5, 1), 1, 0, 0, 0, 1));
    tbl.push_back(vr(ins(1, 6, 1, 0, 0, 1, 5, 0), 1, 0, 0, 0, 2));
    tbl.push_back(vr(ins(1, 5, 1, 0, 0, 1, 9, 0), 1, 0, 0, 0, 2));
    tbl.push_back(vr(nop, 1, 0, 1, 0, 3));
    // r0 write then r0 use
    tbl.push_back(vr(ins(1, 1, 1, 0, 0, 1, 0, 0), 1, 0, 0, 0, 2));
    tbl.push_back(vr(ins(1, 0, 1, 0, 1, 1, 4, 0), 1, 0, 0, 0, 1));
    tbl.push_back(vr(nop, 1, 0, 0, 0, 1));
    // load-use under flush
    tbl.push_back(vr(ins(1, 1, 1, 0, 0, 1, 5, 1), 1, 0, 0, 0, 1));
    tbl.push_back(vr(ins(1, 2, 1, 5, 1, 1, 7, 0, 1), 1, 0, 0, 0, 2));
    tbl.push_back(vr(nop, 1, 0, 0, 0, 1));
    // freeze for 3 cycles mid hazard
    tbl.push_back(vr(ins(1, 1, 1, 0, 0, 1, 3, 0), 1, 0, 0, 0, 1));
    tbl.push_back(vr(ins(1, 3, 1, 0, 0, 1, 8, 1), 1, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(vr(ins(1, 8, 1, 0, 0, 1, 9, 0, 0, 0), 1, 1, 1, 0, 2));
    tbl.push_back(vr(frz, 1, 1, 1, 0, 2));
    tbl.push_back(vr(frz, 1, 0, 0, 0, 2));
    tbl.push_back(vr(nop, 1, 0, 2, 0, 2));

    foreach (tbl[k])
      drive(tbl[k].i, tbl[k].c, tbl[k].st,
            tbl[k].frs, tbl[k].frt, tbl[k].pc);

    // deeper instance: load-use needs two stall cycles
    for (int k = 0; k < 4; k++) drive(nop, 0, 0, 0, 0, 0);
    drive(ins(1, 1, 1, 0, 0, 1, 5, 1), 0, 0, 0, 0, 0);
    scnt = 0;
    for (int k = 0; k < 10; k++) begin
      drive(addu, 0, 0, 0, 0, 0);
      if (!lb_stall) break;
      scnt++;
    end
    chk("b_loaduse_stalls", scnt, 2);
    drive(nop, 0, 0, 0, 0, 0);
    chk("b_loaduse_fwd_rt", {30'b0, lb_frt}, 3);

    for (int k = 0; k < 600; k++) begin
      in_t r;
      r = ins($urandom_range(0, 1),
              5'($urandom % 8), $urandom_range(0, 1),
              5'($urandom % 8), $urandom_range(0, 1),
              $urandom_range(0, 1), 5'($urandom % 8),
              $urandom_range(0, 1),
              ($urandom % 8) == 0,
              ($urandom % 8) != 0,
              ($urandom % 97) != 0);
      drive(r, 0, 0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_scoreboard.md
Name: pipe_hazard_scoreboard

Overview:
- Parametrised hazard scoreboard for the pipelined datapath.
- Tracks in-flight register writes from EX through WB and raises a load-use stall for the ID stage.
- Produces per-operand forwarding selects for the instruction currently in EX.
- Generalises hazard handling to configurable pipeline depth, register count and load latency, with flush support; sits beside the ID/EX/MEM/WB pipeline registers.

Parameters:
- ADDR_W, 5, register address width; register 0 is hardwired zero and never tracked.
- DEPTH, 3, tracked stages after ID. Entry 0 = EX, 1 = MEM, ..., DEPTH-1 = WB. Legal range 2..8.
- LOAD_LAT, 1, a load result is forwardable only from entry index >= LOAD_LAT. Legal range 1..DEPTH-1.
- FLUSH_STAGES, 1, number of youngest entries (indices 0..FLUSH_STAGES-1) invalidated by flush.

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, synchronous, active-low
- enable  in  1  pipeline advance; 0 freezes all state
- id_valid  in  1  ID holds a real instruction
- id_rs  in  ADDR_W  ID source 1
- id_rt  in  ADDR_W  ID source 2
- id_uses_rs  in  1  ID reads rs
- id_uses_rt  in  1  ID reads rt
- id_wr_en  in  1  ID writes a register
- id_waddr  in  ADDR_W  ID destination
- id_is_load  in  1  ID is a load
- flush  in  1  taken branch/jump; kill young instructions
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- fwd_sel_rs  out  clog2(DEPTH)  EX rs source: 0 = ID/EX operand, k = result held by entry k (1..DEPTH-1)
- fwd_sel_rt  out  clog2(DEPTH)  same for rt
- pend_cnt  out  clog2(DEPTH+1)  number of valid entries

Behaviour:
- Entry fields: {valid, waddr, is_load}. EX source regs ex_rs/ex_rt, each with a use bit, held alongside entry 0.
- Reset (sync, arst_n=0 at posedge): all entries invalid, ex_rs = ex_rt = 0, use bits 0. stall = 0, fwd_sel_* = 0, pend_cnt = 0 in the following cycle.
- Match: entry valid, waddr == source, source != 0, source's use bit set. Only the youngest (lowest index) match counts.
- Stall (combinational): for rs or rt of ID, youngest match is a load at index < LOAD_LAT. Gated by id_valid. Forced 0 when flush = 1.
- Forward (combinational from EX state): youngest match for ex_rs/ex_rt among entries 1..DEPTH-1. The index is output, 0 if no match. Entry 0 is the EX instruction itself and is never a forward source.
- Update at posedge when enable = 1:
  - entries k >= 1 take entry k-1 (entry DEPTH-1 retires).
  - entry 0 and ex regs take ID info if id_valid & !stall & !flush; else bubble (valid = 0, use bits 0).
  - entry 0 valid additionally requires id_wr_en & id_waddr != 0.
  - flush: after shifting, entries with index < FLUSH_STAGES are invalidated and their use bits cleared.
- enable = 0: all state held; outputs still reflect held state.
- Simultaneous flush + stall: flush wins, stall = 0, bubble inserted.
- Latency:
  - stall: same cycle as ID contents.
  - fwd_sel: valid the cycle the consumer is in EX, i.e. one cycle after issue.
- pend_cnt = popcount of entry valid bits, registered with the entries.

Optional Feature:
- HAZARD_STATS_EN defined: adds outputs stall_cycles (32 bit) and fwd_events (32 bit), both reset to 0 by arst_n.
  - stall_cycles increments each enabled cycle with stall = 1.
  - fwd_events increments by the number of nonzero fwd_sel outputs (0..2) per enabled cycle.
  - Both saturate at 0xFFFFFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset with arst_n = 0 for 2 cycles while all inputs toggle -> stall = 0, fwd_sel_rs = fwd_sel_rt = 0, pend_cnt = 0 after the first edge.
- Issue add r3 (wr r3), then sub using rs = r3 next cycle -> fwd_sel_rs = 1 while sub is in EX. Insert one unrelated instruction between them -> fwd_sel_rs = 2.
- Issue lw r5, then add using rt = r5 -> stall = 1 for exactly 1 cycle with bubble in EX. Add then in EX -> fwd_sel_rt = 2. With LOAD_LAT = 2, DEPTH = 4 -> 2 stall cycles.
- Issue lw r5, then addi r5, then use of r5 -> no stall (younger non-load shadows), fwd_sel_rs = 1. Write to r0 followed by use of r0 -> never stall, fwd 0.
- Load-use hazard present with flush = 1 -> stall = 0, entry 0 invalid next cycle, pend_cnt drops accordingly. enable = 0 for 3 cycles mid-sequence -> entries and outputs frozen, then resume correctly.
- HAZARD_STATS_EN: run the load-use scenario twice plus one forward -> stall_cycles = 2, fwd_events = 3.
